// File: rtl/dfe_pkg.sv
// Shared types and constants for the sensor frame packer.
// Header byte layout: {tag nibble, sequence nibble}.
package dfe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } pack_state_t;

    localparam int TAG_W    = 4;
    localparam int SEQ_W    = 4;
    localparam int BYTE_W   = TAG_W + SEQ_W;
    localparam int CNT_W    = 8;

    localparam logic [TAG_W-1:0] HDR_TAG_DEF = 4'hA;

endpackage

// File: rtl/sens_stage_fifo.sv
// Small staging buffer between sensor capture and the frame FSM.
// Extra pointer MSB distinguishes full from empty; push/pop are pre-qualified by the caller.
module sens_stage_fifo
    import dfe_pkg::*;
#(
    parameter int STAGE_DEPTH = 4,
    parameter int STAGE_AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    logic [BYTE_W-1:0] mem [STAGE_DEPTH];
    logic [STAGE_AW:0] wr_ptr;
    logic [STAGE_AW:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[STAGE_AW] != rd_ptr[STAGE_AW]) &&
                      (wr_ptr[STAGE_AW-1:0] == rd_ptr[STAGE_AW-1:0]);
    assign pop_data = mem[rd_ptr[STAGE_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[STAGE_AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sens_frame_packer.sv
// Packs sensor bytes into {header, FRAME_LEN data bytes, XOR checksum} frames
// for the streaming FIFO, with drop counting when staging overflows.
//
//   state   | meaning
//   IDLE    | no frame open; re-samples enable
//   HDR     | waiting to write header {HDR_TAG, seq}
//   DATA    | moving staged bytes to the FIFO, accumulating XOR
//   CSUM    | waiting to write checksum, then bump seq
module sens_frame_packer
    import dfe_pkg::*;
#(
    parameter int               FRAME_LEN   = 4,
    parameter int               STAGE_DEPTH = 4,
    parameter int               STAGE_AW    = 2,
    parameter logic [TAG_W-1:0] HDR_TAG     = HDR_TAG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  sens_data,
    input  logic        sens_data_val,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        overflow,
    input  logic        clr_overflow,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    pack_state_t       state;
    logic              enable_q;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        acc;
    logic [SEQ_W-1:0]  seq;

    logic              capture;
    logic              push;
    logic              pop;
    logic              drop;
    logic              stg_full;
    logic              stg_empty;
    logic [7:0]        stg_dout;

    sens_stage_fifo #(
        .STAGE_DEPTH (STAGE_DEPTH),
        .STAGE_AW    (STAGE_AW)
    ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sens_data),
        .pop       (pop),
        .pop_data  (stg_dout),
        .full      (stg_full),
        .empty     (stg_empty)
    );

    // A pop on the same edge frees a slot, so a full buffer can still accept.
    assign capture = enable_q && sens_data_val;
    assign pop     = (state == ST_DATA) && !stg_empty && !fifo_full;
    assign push    = capture && (!stg_full || pop);
    assign drop    = capture && stg_full && !pop;
    assign busy    = (state != ST_IDLE) || !stg_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            enable_q     <= 1'b0;
            byte_cnt     <= '0;
            acc          <= '0;
            seq          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (state == ST_IDLE) begin
                enable_q <= enable;
            end
            case (state)
                ST_IDLE: begin
                    // Leaving on the capturing edge keeps the header one cycle behind the sample.
                    if (!stg_empty || push) begin
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!fifo_full) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= {HDR_TAG, seq};
                        acc          <= '0;
                        byte_cnt     <= CNT_W'(FRAME_LEN - 1);
                        state        <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (pop) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= stg_dout;
                        acc          <= acc ^ stg_dout;
                        if (byte_cnt == '0) begin
                            state <= ST_CSUM;
                        end else begin
                            byte_cnt <= byte_cnt - 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (!fifo_full) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= acc;
                        seq          <= seq + SEQ_W'(1);
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Clear takes priority, but a drop on the same edge is still recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_overflow) begin
            overflow <= drop;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sens_frame_packer.sv
// Self-checking bench for sens_frame_packer: scoreboard of expected FIFO writes
// plus table-driven frames and hand-written corner sequences.
module tb_sens_frame_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] sens_data;
    logic       sens_data_val;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       overflow;
    logic       clr_overflow;
    logic [7:0] drop_cnt;
    logic       busy;

    sens_frame_packer #(
        .FRAME_LEN   (4),
        .STAGE_DEPTH (4),
        .STAGE_AW    (2),
        .HDR_TAG     (4'hA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sens_data     (sens_data),
        .sens_data_val (sens_data_val),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  csum;
    } vec_t;

    vec_t       vecs [4];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    int         wr_cyc [$];
    int         cyc = 0;
    int         wr_total = 0;
    logic       ff_at_edge = 1'b0;
    logic [3:0] exp_seq = 4'd0;

    always @(posedge clk) begin
        cyc++;
        ff_at_edge = fifo_full;
    end

    // Scoreboard: every FIFO write is compared against the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
            logic [7:0] e;
            wr_total++;
            wr_cyc.push_back(cyc);
            checks++;
            if (ff_at_edge) begin
                errors++;
                $display("FAIL wr_while_full: wr_en=1 with fifo_full=1 at cycle %0d", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h, expected no write", fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wr_data !== e) begin
                    errors++;
                    $display("FAIL wr_data: got %h, expected %h", fifo_wr_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        sens_data     = b;
        sens_data_val = 1'b1;
        tick();
        sens_data_val = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            send(d[31-8*i -: 8]);
        end
    endtask

    function automatic logic [7:0] model_csum(input logic [31:0] d);
        return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    task automatic expect_frame(input logic [31:0] d, input logic [7:0] cs);
        exp_q.push_back({4'hA, exp_seq});
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(d[31-8*i -: 8]);
        end
        exp_q.push_back(cs);
        exp_seq = exp_seq + 4'd1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes outstanding, busy=%0b", exp_q.size(), busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          n0;
        logic [31:0] d;

        vecs[0] = '{data: 32'h11223344, csum: 8'h44};
        vecs[1] = '{data: 32'h01020304, csum: 8'h04};
        vecs[2] = '{data: 32'hFF00FF00, csum: 8'h00};
        vecs[3] = '{data: 32'h12345678, csum: 8'h08};

        rst_n = 1'b0; enable = 1'b0; sens_data = '0; sens_data_val = 1'b0;
        fifo_full = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(); tick();

        // Basic frame with latency checks, then the rest of the table.
        wr_cyc.delete();
        expect_frame(vecs[0].data, vecs[0].csum);
        send(vecs[0].data[31:24]);
        k = cyc;
        send(vecs[0].data[23:16]);
        send(vecs[0].data[15:8]);
        send(vecs[0].data[7:0]);
        drain();
        check("lat_count", wr_cyc.size(), 6);
        if (wr_cyc.size() == 6) begin
            check("lat_header", wr_cyc[0], k + 1);
            check("lat_data0", wr_cyc[1], k + 2);
            check("lat_csum", wr_cyc[5], k + 6);
        end
        for (int i = 1; i < 4; i++) begin
            expect_frame(vecs[i].data, vecs[i].csum);
            send_frame(vecs[i].data);
            drain();
        end

        // Backpressure: fifo_full held for 10 edges right after the header.
        d = 32'hDEADBEEF;
        expect_frame(d, model_csum(d));
        send(d[31:24]);
        send(d[23:16]);
        fifo_full = 1'b1;
        send(d[15:8]);
        n0 = wr_total;
        send(d[7:0]);
        repeat (8) tick();
        check("bp_no_write", wr_total - n0, 0);
        fifo_full = 1'b0;
        drain();

        // Overflow: 8 samples into a stalled packer.
        fifo_full = 1'b1;
        expect_frame(32'h80818283, model_csum(32'h80818283));
        for (int i = 0; i < 8; i++) begin
            send(8'h80 + 8'(i));
        end
        check("ovf_drop_cnt", drop_cnt, 4);
        check("ovf_flag", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr_drop_cnt", drop_cnt, 0);
        check("clr_flag", overflow, 0);
        clr_overflow = 1'b1;
        send(8'h99);
        clr_overflow = 1'b0;
        check("clr_drop_same_cnt", drop_cnt, 1);
        check("clr_drop_same_flag", overflow, 1);
        repeat (300) send(8'h55);
        check("sat_drop_cnt", drop_cnt, 255);
        fifo_full = 1'b0;
        drain();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr2_drop_cnt", drop_cnt, 0);

        // Sequence wrap: 17 frames of random data.
        for (int i = 0; i < 17; i++) begin
            d = $urandom;
            expect_frame(d, model_csum(d));
            send_frame(d);
            drain();
        end

        // Enable gating.
        enable = 1'b0;
        tick(); tick();
        n0 = wr_total;
        for (int i = 0; i < 5; i++) begin
            send(8'hE0 + 8'(i));
        end
        repeat (4) tick();
        check("gate_no_write", wr_total - n0, 0);
        check("gate_drop_cnt", drop_cnt, 0);
        check("gate_busy", busy, 0);

        // Enable falls mid-frame: the frame still completes.
        enable = 1'b1;
        tick();
        d = 32'h5A6B7C8D;
        expect_frame(d, model_csum(d));
        send(d[31:24]);
        send(d[23:16]);
        enable = 1'b0;
        repeat (3) tick();
        send(d[15:8]);
        send(d[7:0]);
        drain();
        send(8'h77);
        tick();
        check("gate_after_frame_busy", busy, 0);

        // Reset after header plus two data bytes.
        enable = 1'b1;
        tick(); tick();
        exp_q.push_back({4'hA, exp_seq});
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        send_frame(32'hC0C1C2C3);
        #5;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", fifo_wr_en, 0);
        check("midrst_wr_data", fifo_wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_seen", exp_q.size(), 0);
        exp_q.delete();
        exp_seq = 4'd0;
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        tick(); tick();
        d = 32'hA5A6A7A8;
        expect_frame(d, model_csum(d));
        send_frame(d);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sens_frame_packer.md
Name: sens_frame_packer

Overview:
- Ingest stage between the sensor byte interface (sens_data/sens_data_val) and the streaming FIFO write port.
- Groups accepted sensor bytes into fixed-length frames. Each frame is emitted as a header byte, then the data bytes, then an XOR checksum byte.
- Absorbs header/checksum insertion and FIFO backpressure in a small staging buffer. Drops and counts samples when that buffer is full.

Parameters:
- FRAME_LEN, 4, data bytes per frame (2..255)
- STAGE_DEPTH, 4, staging buffer entries (power of 2, >=2)
- STAGE_AW, 2, log2(STAGE_DEPTH)
- HDR_TAG, 4'hA, upper nibble of header byte

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  packing enable, sampled at frame boundaries
- sens_data  in  8  sensor byte
- sens_data_val  in  1  sens_data valid, single-cycle qualifier, no ready/stall path
- fifo_full  in  1  streaming FIFO full
- fifo_wr_en  out  1  FIFO write strobe, registered
- fifo_wr_data  out  8  FIFO write byte, registered
- overflow  out  1  sticky: at least one sample dropped
- clr_overflow  in  1  synchronous clear of overflow and drop_cnt
- drop_cnt  out  8  dropped-sample count, saturates at 255
- busy  out  1  high when FSM is not IDLE or staging is non-empty

Behaviour:
- Reset: all outputs 0; FSM=IDLE; staging empty; seq=0; checksum accumulator=0.
- Capture, when enable_q=1 and sens_data_val=1:
  - staging not full: byte written at that edge.
  - staging full: byte dropped; overflow<=1; drop_cnt increments, saturating at 255.
- enable_q: enable is re-sampled only while the FSM is in IDLE. While enable_q=0, samples are ignored and not counted as drops.
- A frame in progress always completes, even if enable falls.
- clr_overflow with a simultaneous drop: clear wins, then count=1 and overflow=1 on that same edge.
- FSM states IDLE, HDR, DATA, CSUM:
  - IDLE -> HDR when staging is non-empty.
  - HDR: when !fifo_full, drive wr_en=1, wr_data={HDR_TAG, seq[3:0]}, clear the accumulator, go to DATA.
  - DATA: when staging is non-empty and !fifo_full, pop one byte, write it, and XOR it into the accumulator. After FRAME_LEN pops, go to CSUM.
  - CSUM: when !fifo_full, write the accumulator, seq<=seq+1 (wraps 15->0), go to IDLE.
- Backpressure: fifo_wr_en is never asserted in a cycle where fifo_full is high. The decision uses the fifo_full value sampled on the same edge that registers wr_en.
- If the state has no write permitted, wr_en=0 and wr_data holds its previous value.
- Latency, staging empty, fifo_full=0, sample captured at edge k:
  - header visible after edge k+1;
  - first data byte after edge k+2;
  - each later data byte one cycle after it is available.
- Throughput: a frame costs FRAME_LEN+2 write cycles. Sustained input faster than FRAME_LEN/(FRAME_LEN+2) overflows the staging buffer by design.
- Staging buffer:
  - pointers of STAGE_AW+1 bits, full/empty from MSB compare;
  - simultaneous push and pop when full is allowed: the pop frees the slot on the same edge, so the push is accepted;
  - simultaneous push and pop when empty: push is accepted, no pop that cycle.
- Reset asserted mid-frame: frame abandoned, no partial checksum emitted, seq returns to 0, staging flushed.

Decomposition:
- Package dfe_pkg:
  - packer state enum (IDLE/HDR/DATA/CSUM, 2-bit);
  - HDR_TAG default;
  - header-field widths.
- Sub-module sens_stage_fifo: the STAGE_DEPTH x 8 staging buffer with push/pop/full/empty. The FSM, checksum, seq and counters stay in the top.

Test Plan:
- Basic frame: FRAME_LEN=4, enable=1, fifo_full=0, bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> writes A0,11,22,33,44,44. A second frame starts with header A1.
- Backpressure: fifo_full=1 held for 10 cycles after the header -> no wr_en during those cycles. After release, the remaining bytes and checksum are written in order, none lost or duplicated.
- Overflow: fifo_full=1 and 8 back-to-back samples -> 4 stored, drop_cnt=4, overflow=1. clr_overflow pulse -> both 0. 300 drops -> drop_cnt=255.
- Sequence wrap: 17 complete frames -> headers A0..AF then A0.
- Enable gating: enable=0 with 5 samples -> no writes, drop_cnt=0. Enable falls mid-frame -> the frame still completes when its remaining samples arrive.
- Reset mid-frame: rst_n low after header plus 2 data bytes -> outputs 0 and busy=0. The next frame starts with header A0 and no stale bytes.
